// File: rtl/led_matrix_pkg.sv
// Shared constants and type definitions for the LED matrix scan controller.
package led_matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  typedef enum logic [1:0] {
    IRR_OK        = 2'b00,
    IRR_WATERING  = 2'b01,
    IRR_LOW_WATER = 2'b10,
    IRR_FAULT     = 2'b11
  } irr_status_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [2:0] col);
    logic [7:0] t;
    t = 8'd1 << col;
    return t[NUM_COLS-1:0];
  endfunction

endpackage

// File: rtl/irrigation_status_pattern_rom.sv
// Combinational glyph lookup: irrigation status and column index to row bits.
module irrigation_status_pattern_rom
  import led_matrix_pkg::*;
(
  input  logic [1:0]          status,
  input  logic [2:0]          col,
  output logic [NUM_ROWS-1:0] rows
);

  always_comb begin
    rows = '0;
    case (irr_status_e'(status))
      IRR_OK: begin
        if (col < 3'(NUM_COLS)) rows = 7'h7F;
      end
      IRR_WATERING: begin
        case (col)
          3'd0: rows = 7'h01;
          3'd1: rows = 7'h03;
          3'd2: rows = 7'h07;
          3'd3: rows = 7'h0F;
          3'd4: rows = 7'h01;
          default: rows = '0;
        endcase
      end
      IRR_LOW_WATER: begin
        case (col)
          3'd0: rows = 7'h41;
          3'd1: rows = 7'h22;
          3'd2: rows = 7'h14;
          3'd3: rows = 7'h22;
          3'd4: rows = 7'h41;
          default: rows = '0;
        endcase
      end
      IRR_FAULT: begin
        case (col)
          3'd0: rows = 7'h7F;
          3'd1: rows = 7'h00;
          3'd2: rows = 7'h7F;
          3'd3: rows = 7'h00;
          3'd4: rows = 7'h01;
          default: rows = '0;
        endcase
      end
      default: rows = '0;
    endcase
  end

endmodule

// File: rtl/led_matrix_scan_controller.sv
// Column-multiplexed LED matrix scanner showing an irrigation status glyph,
// with per-slot blanking and a status snapshot taken once per frame.
module led_matrix_scan_controller
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          irrigation_status,
  output logic [NUM_COLS-1:0] columns,
  output logic [NUM_ROWS-1:0] rows,
  output logic                frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);

  scan_state_e         state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [2:0]          col_q, col_d;
  logic [1:0]          status_q, status_d;
  logic [NUM_COLS-1:0] columns_q, columns_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d;
  logic                frame_done_q, frame_done_d;

  logic                div_wrap;
  logic                frame_wrap;
  logic [NUM_ROWS-1:0] pattern;

  assign div_wrap   = (div_cnt_q == DIV_MAX);
  assign frame_wrap = (state_q == ST_SCAN) && div_wrap && (col_q == 3'(NUM_COLS - 1));

  irrigation_status_pattern_rom u_rom (
    .status (status_q),
    .col    (col_q),
    .rows   (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      col_q        <= '0;
      status_q     <= 2'b00;
      columns_q    <= '0;
      rows_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      col_q        <= col_d;
      status_q     <= status_d;
      columns_q    <= columns_d;
      rows_q       <= rows_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    col_d     = col_q;
    status_d  = status_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_SCAN;
          div_cnt_d = '0;
          col_d     = '0;
          status_d  = irrigation_status;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          col_d     = '0;
        end else begin
          div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
          if (col_q >= 3'(NUM_COLS)) begin
            col_d = '0;
          end else if (div_wrap) begin
            col_d = (col_q == 3'(NUM_COLS - 1)) ? 3'd0 : col_q + 3'd1;
          end
          // Snapshot taken only at the frame boundary so a glyph never tears.
          if (frame_wrap) status_d = irrigation_status;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output drive is gated by enable directly so the panel blanks one cycle after it drops.
  always_comb begin
    columns_d    = '0;
    rows_d       = '0;
    frame_done_d = frame_wrap;
    if ((state_q == ST_SCAN) && enable) begin
      columns_d = col_onehot(col_q);
      if (div_cnt_q >= BLANK_LIM) rows_d = pattern;
    end
  end

  assign columns    = columns_q;
  assign rows       = rows_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Scoreboard bench for the LED matrix scan controller at CLK_DIV=8, BLANK_CYCLES=2.
module tb_led_matrix_scan_controller;

  localparam int CD = 8;
  localparam int BL = 2;
  localparam int FRAME = 5 * CD;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] irrigation_status;
  logic [4:0] columns;
  logic [6:0] rows;
  logic       frame_done;

  led_matrix_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .irrigation_status (irrigation_status),
    .columns           (columns),
    .rows              (rows),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] c;
    logic [6:0] r;
    logic       f;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  bit         m_act = 0;
  int         m_n = 0;
  logic [1:0] m_st = 2'b00;
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_prev = -1;
  bit         fd_track = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [6:0] pat(input logic [1:0] st, input int col);
    logic [6:0] t [5];
    case (st)
      2'b00: t = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      2'b01: t = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h01};
      2'b10: t = '{7'h41, 7'h22, 7'h14, 7'h22, 7'h41};
      default: t = '{7'h7F, 7'h00, 7'h7F, 7'h00, 7'h01};
    endcase
    return t[col];
  endfunction

  task automatic step(input logic en, input logic [1:0] st);
    exp_t e;
    exp_t got;
    int col;
    @(negedge clk);
    enable = en;
    irrigation_status = st;
    col = (m_n / CD) % 5;
    e = '0;
    if (m_act && en) begin
      e.c = 5'(1 << col);
      e.r = ((m_n % CD) < BL) ? 7'h00 : pat(m_st, col);
    end
    e.f = m_act && ((m_n % FRAME) == FRAME - 1);
    sb.push_back(e);
    if (!en) begin
      m_act = 0;
      m_n = 0;
    end else if (!m_act) begin
      m_act = 1;
      m_n = 0;
      m_st = st;
    end else begin
      if ((m_n % FRAME) == FRAME - 1) m_st = st;
      m_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    got = sb.pop_front();
    check("columns", 32'(columns), 32'(got.c));
    check("rows", 32'(rows), 32'(got.r));
    check("frame_done", 32'(frame_done), 32'(got.f));
    if (frame_done === 1'b1) begin
      if (fd_track && fd_prev >= 0) check("fd_spacing", 32'(cyc - fd_prev), 32'(FRAME));
      fd_prev = cyc;
      fd_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int k;
    rst_n = 1'b0;
    enable = 1'b0;
    irrigation_status = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_columns", 32'(columns), 32'h0);
    check("rst_rows", 32'(rows), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);

    // Three full frames with status 00, pulses should be 40 cycles apart.
    fd_track = 1;
    base = fd_cnt;
    for (int i = 0; i < 1 + 3 * FRAME; i++) step(1'b1, 2'b00);
    check("fd_count_3frames", 32'(fd_cnt - base), 32'd3);
    fd_track = 0;

    // Status changes mid column 2; the current frame must keep the 00 glyph.
    for (int i = 0; i < 20; i++) step(1'b1, 2'b00);
    for (int i = 0; i < 60; i++) step(1'b1, 2'b01);
    for (int i = 0; i < FRAME; i++) step(1'b1, 2'b10);
    for (int i = 0; i < FRAME; i++) step(1'b1, 2'b11);

    // Drop enable in column 3, then restart.
    for (k = 0; k < 60 && ((m_n / CD) % 5) != 3; k++) step(1'b1, 2'b11);
    check("reach_col3", 32'(((m_n / CD) % 5) == 3), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b11);
    for (int i = 0; i < 24; i++) step(1'b1, 2'b10);

    // Enable falls exactly on the frame wrap.
    for (k = 0; k < 60 && (m_n % FRAME) != FRAME - 1; k++) step(1'b1, 2'b10);
    check("reach_wrap", 32'((m_n % FRAME) == FRAME - 1), 32'd1);
    base = fd_cnt;
    for (int i = 0; i < 5; i++) step(1'b0, 2'b10);
    check("fd_on_drop", 32'(fd_cnt - base), 32'd1);

    // Reset pulse mid-slot in column 4.
    for (int i = 0; i < 2; i++) step(1'b1, 2'b01);
    for (k = 0; k < 80 && !(((m_n / CD) % 5) == 4 && (m_n % CD) == 4); k++) step(1'b1, 2'b01);
    check("reach_col4_mid", 32'(((m_n / CD) % 5) == 4 && (m_n % CD) == 4), 32'd1);
    check("pre_rst_columns", 32'(columns), 32'h10);
    rst_n = 1'b0;
    #1;
    check("async_rst_columns", 32'(columns), 32'h0);
    check("async_rst_rows", 32'(rows), 32'h0);
    check("async_rst_frame_done", 32'(frame_done), 32'h0);
    m_act = 0;
    m_n = 0;
    m_st = 2'b00;
    irrigation_status = 2'b11;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 1 + FRAME + 4; i++) step(1'b1, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_controller.md
LED_MATRIX_SCAN_CONTROLLER -- requirements
Module: led_matrix_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per column slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYCLES, default 2, cycles of rows-off at the start of each slot; legal range 1..CLK_DIV-1.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scanning runs while high.
- irrigation_status  input  2  current irrigation condition code.
- columns  output  5  one-hot column drive, active high.
- rows  output  7  row drive for the active column, active high.
- frame_done  output  1  one-cycle pulse at the end of column 4's slot.

Function
REQ-005 Divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0, advancing only while enable=1.
REQ-006 Column index col SHALL advance 0→1→2→3→4→0 on the cycle where div_cnt wraps.
REQ-007 irrigation_status SHALL be sampled into status_q only when col wraps 4→0, and at the first enabled cycle after reset; mid-frame input changes SHALL NOT alter the current frame.
REQ-008 columns SHALL be one-hot at bit col while enable=1, and 5'b00000 while enable=0.
REQ-009 rows SHALL be 7'b0000000 while div_cnt < BLANK_CYCLES, otherwise pattern(status_q, col); outputs SHALL be registered (one cycle after the internal state).
REQ-010 pattern(status, col) SHALL be a pure lookup of status 0..3 and col 0..4; for col 4: status 2'b00→7'h7F, 2'b01→7'h01, 2'b10→7'h41, 2'b11→7'h01.
REQ-011 frame_done SHALL pulse high for exactly one cycle on the cycle col wraps 4→0.
REQ-012 States: IDLE (enable=0) and SCAN (enable=1); IDLE→SCAN on enable rising, with col=0, div_cnt=0 and a fresh status sample; SCAN→IDLE on enable falling, which clears div_cnt and col to 0 on the next cycle.
REQ-013 If enable falls on the same cycle as a 4→0 wrap, frame_done SHALL still pulse and the state SHALL still go to IDLE.
REQ-014 Counter widths SHALL be $clog2(CLK_DIV) for div_cnt and 3 bits for col; col values 5..7 are illegal and SHALL force col to 0 on the next cycle.

Reset
REQ-015 While rst_n=0: columns=0, rows=0, frame_done=0, div_cnt=0, col=0, status_q=2'b00, state=IDLE.
REQ-016 Reset assertion mid-slot SHALL clear all outputs asynchronously, with no glitch to a non-zero column.
REQ-017 The first enabled cycle after rst_n deasserts SHALL behave as the IDLE→SCAN entry.

Structure
REQ-018 Shared package led_matrix_pkg SHALL hold NUM_COLS=5, NUM_ROWS=7 and the named irrigation status codes.
REQ-019 The lookup SHALL be one combinational sub-module, irrigation_status_pattern_rom (status, col → rows); the divider, column sequencer and output registers stay in the top level.

Verification
REQ-020 CLK_DIV=8, BLANK_CYCLES=2, status=2'b00, enable=1 -> columns steps through 1,2,4,8,16 every 8 cycles; rows=0 for 2 cycles, then 7'h7F in column 4.
REQ-021 Status changes 00→01 during column 2 -> rows keep the 00 patterns until frame_done, and column 4 of the next frame shows 7'h01.
REQ-022 frame_done counted over 3 frames with CLK_DIV=8 -> exactly 3 single-cycle pulses, spaced 40 cycles apart.
REQ-023 enable dropped in column 3 then raised again -> columns=0 and rows=0 while disabled; restart at column 0 with div_cnt=0.
REQ-024 rst_n pulsed low in column 4 mid-slot -> all outputs 0 immediately; after release, restart at column 0 with status_q resampled.
REQ-025 enable falls on the 4→0 wrap cycle -> one frame_done pulse, then columns=0.
